// File: rtl/de1_input_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// de1_input_pkg : shared constants and key FSM state type for the DE1 input
//                 conditioner.                                   Rev 1.0
// ---------------------------------------------------------------------------
package de1_input_pkg;

  localparam int DEBOUNCE_CYCLES_DEF  = 50000;
  localparam int SW_SAMPLE_CYCLES_DEF = 50000;
  localparam int NUM_KEYS             = 2;
  localparam int NUM_SW               = 10;

  typedef enum logic [1:0] {
    KEY_RELEASED        = 2'd0,
    KEY_PRESS_PENDING   = 2'd1,
    KEY_PRESSED         = 2'd2,
    KEY_RELEASE_PENDING = 2'd3
  } key_state_e;

endpackage
`default_nettype wire

// File: rtl/key_debounce_ch.sv
`default_nettype none
// ---------------------------------------------------------------------------
// key_debounce_ch : one push-button channel -- synchronizer, debounce FSM,
//                   saturating stability counter and press/release strobes.
//                                                                Rev 1.0
// ---------------------------------------------------------------------------
module key_debounce_ch
  import de1_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic n_reset,
  input  logic key_raw,
  output logic button,
  output logic press_pulse,
  output logic release_pulse
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]       key_sync;
  logic             pressed;
  logic [CNT_W-1:0] cnt;
  key_state_e       state;

  // Keys are active-low; the FSM works on the pressed (active-high) level.
  assign pressed = ~key_sync[1];

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      key_sync      <= 2'b11;
      state         <= KEY_RELEASED;
      cnt           <= '0;
      button        <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      key_sync      <= {key_sync[0], key_raw};
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      case (state)
        KEY_RELEASED: begin
          if (pressed) begin
            state <= KEY_PRESS_PENDING;
            cnt   <= '0;
          end
        end
        KEY_PRESS_PENDING: begin
          if (!pressed) begin
            state <= KEY_RELEASED;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state       <= KEY_PRESSED;
            cnt         <= '0;
            button      <= 1'b1;
            press_pulse <= 1'b1;
          end else if (cnt != '1) begin
            cnt <= cnt + CNT_ONE;
          end
        end
        KEY_PRESSED: begin
          if (!pressed) begin
            state <= KEY_RELEASE_PENDING;
            cnt   <= '0;
          end
        end
        KEY_RELEASE_PENDING: begin
          if (pressed) begin
            state <= KEY_PRESSED;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state         <= KEY_RELEASED;
            cnt           <= '0;
            button        <= 1'b0;
            release_pulse <= 1'b1;
          end else if (cnt != '1) begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state <= KEY_RELEASED;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/de1_input_conditioner.sv
`default_nettype none
// ---------------------------------------------------------------------------
// de1_input_conditioner : debounced DE1 push-buttons with edge strobes and
//                         tick-sampled, two-sample-agreement slide switches.
//                                                                Rev 1.0
// ---------------------------------------------------------------------------
module de1_input_conditioner
  import de1_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES  = DEBOUNCE_CYCLES_DEF,
  parameter int SW_SAMPLE_CYCLES = SW_SAMPLE_CYCLES_DEF
) (
  input  logic                CLOCK_50,
  input  logic                nReset,
  input  logic [NUM_KEYS-1:0] KEY,
  input  logic [NUM_SW-1:0]   SW,
  output logic [NUM_KEYS-1:0] Buttons,
  output logic [NUM_KEYS-1:0] press_pulse,
  output logic [NUM_KEYS-1:0] release_pulse,
  output logic [NUM_SW-1:0]   SW_clean
);

  localparam int PRE_W = $clog2(SW_SAMPLE_CYCLES);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SW_SAMPLE_CYCLES - 1);
  localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);

  genvar g;
  generate
    for (g = 0; g < NUM_KEYS; g++) begin : g_key
      key_debounce_ch #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_key (
        .clk          (CLOCK_50),
        .n_reset      (nReset),
        .key_raw      (KEY[g]),
        .button       (Buttons[g]),
        .press_pulse  (press_pulse[g]),
        .release_pulse(release_pulse[g])
      );
    end
  endgenerate

  logic [PRE_W-1:0]  prescaler;
  logic              sw_tick;
  logic [NUM_SW-1:0] sw_meta;
  logic [NUM_SW-1:0] sw_sync;
  logic [NUM_SW-1:0] sw_sample;

  assign sw_tick = (prescaler == PRE_LAST);

  // A switch value is accepted only once two consecutive ticks agree on it.
  always_ff @(posedge CLOCK_50) begin
    if (!nReset) begin
      prescaler <= '0;
      sw_meta   <= '0;
      sw_sync   <= '0;
      sw_sample <= '0;
      SW_clean  <= '0;
    end else begin
      sw_meta   <= SW;
      sw_sync   <= sw_meta;
      prescaler <= sw_tick ? '0 : prescaler + PRE_ONE;
      if (sw_tick) begin
        sw_sample <= sw_sync;
        if (sw_sync == sw_sample) begin
          SW_clean <= sw_sync;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/de1_input_conditioner.md
DE1_INPUT_CONDITIONER -- requirements
Module: de1_input_conditioner

Interface
REQ-001 The parameter DEBOUNCE_CYCLES SHALL have default 50000 and set the number of consecutive stable cycles required to accept a key change (1 ms at 50 MHz); legal range is 2 or more.
REQ-002 The parameter SW_SAMPLE_CYCLES SHALL have default 50000 and set the switch sample-tick period in clock cycles; legal range is 2 or more.
REQ-003 The port CLOCK_50 SHALL be an input, 1 bit wide, and be the single clock for all state.
REQ-004 The port nReset SHALL be an input, 1 bit wide, and be a synchronous, active-low reset.
REQ-005 The port KEY SHALL be an input, 2 bits wide, carrying raw, asynchronous, active-low push-buttons.
REQ-006 The port SW SHALL be an input, 10 bits wide, carrying raw, asynchronous slide switches.
REQ-007 The port Buttons SHALL be an output, 2 bits wide, carrying the debounced active-high button levels.
REQ-008 The port press_pulse SHALL be an output, 2 bits wide, giving a one-cycle strobe per accepted press.
REQ-009 The port release_pulse SHALL be an output, 2 bits wide, giving a one-cycle strobe per accepted release.
REQ-010 The port SW_clean SHALL be an output, 10 bits wide, carrying the debounced switch levels.

Function
REQ-011 Each KEY bit and each SW bit SHALL pass through a 2-flop synchronizer before any other logic.
REQ-012 Each key channel SHALL implement the FSM RELEASED, PRESS_PENDING, PRESSED, RELEASE_PENDING, operating on the inverted synchronized key.
REQ-013 RELEASED SHALL go to PRESS_PENDING when the synced key is pressed; the counter is cleared on entry.
REQ-014 In PRESS_PENDING, the counter SHALL increment each cycle the key stays pressed; when the count reaches DEBOUNCE_CYCLES-1 with the key still pressed, the FSM goes to PRESSED and Buttons[n] is set.
REQ-015 In PRESS_PENDING, a single released sample SHALL abort to RELEASED with the counter cleared and no pulse.
REQ-016 PRESSED and RELEASE_PENDING SHALL mirror REQ-013 to REQ-015 with the key polarity swapped.
REQ-017 press_pulse[n] SHALL be high for exactly the one cycle in which Buttons[n] rises; release_pulse[n] SHALL be high for exactly the one cycle in which Buttons[n] falls.
REQ-018 Latency SHALL be as follows: a clean pin edge held steady changes Buttons exactly DEBOUNCE_CYCLES+2 cycles after the first clock edge that samples the new pin level.
REQ-019 Glitches shorter than DEBOUNCE_CYCLES cycles at the synchronizer output SHALL never change Buttons or produce a pulse.
REQ-020 The counter width SHALL be $clog2(DEBOUNCE_CYCLES); the counter SHALL saturate and never wrap.
REQ-021 The two key channels SHALL be fully independent, so simultaneous presses produce simultaneous pulses.
REQ-022 The switch path SHALL use one free-running prescaler that emits a tick every SW_SAMPLE_CYCLES cycles, wrapping from SW_SAMPLE_CYCLES-1 to 0.
REQ-023 On each tick, the synced SW SHALL be captured into sw_sample; if the new capture equals the previous sw_sample, SW_clean SHALL load it, otherwise SW_clean holds.
REQ-024 A switch change held steady SHALL appear on SW_clean within 2*SW_SAMPLE_CYCLES+3 cycles; a switch bounce that never survives two consecutive ticks SHALL never reach SW_clean.

Reset
REQ-025 While nReset is sampled low at a CLOCK_50 edge, the key synchronizers SHALL be set to 1 (the key-released level).
REQ-026 While nReset is sampled low at a CLOCK_50 edge, the SW synchronizers, sw_sample, SW_clean, the prescaler and all counters SHALL be set to 0.
REQ-027 While nReset is sampled low at a CLOCK_50 edge, the FSMs SHALL be set to RELEASED and Buttons, press_pulse and release_pulse SHALL be set to 0.
REQ-028 A reset asserted mid-debounce or while a key is PRESSED SHALL clear the state without emitting a release_pulse.
REQ-029 A key already held when reset deasserts SHALL then be debounced normally and produce a press_pulse.

Structure
REQ-030 The shared package de1_input_pkg SHALL hold the key FSM state enum, the default DEBOUNCE_CYCLES and SW_SAMPLE_CYCLES constants, and the key count (2) and switch count (10).
REQ-031 The single sub-module key_debounce_ch SHALL contain the synchronizer, FSM, counter and pulse outputs for one key, and SHALL be instantiated twice.
REQ-032 The switch path SHALL be implemented inline in the top module.

Verification
REQ-033 The bench SHALL use DEBOUNCE_CYCLES=16 and SW_SAMPLE_CYCLES=8 for all scenarios.
REQ-034 Scenario 1: hold KEY[0] low for 50 cycles, then release -> Buttons[0] rises 18 cycles after the low edge with one press_pulse, falls 18 cycles after release with one release_pulse.
REQ-035 Scenario 2: a 10-cycle low glitch on KEY[1], then four 3-cycle low glitches spaced 3 cycles apart -> Buttons stays 2'b00, and no pulses occur.
REQ-036 Scenario 3: press KEY[0] and KEY[1] on the same edge for 40 cycles -> both press_pulse bits assert on the same cycle.
REQ-037 Scenario 4: step SW through 0, 1, 2, 3, 4 then 15, each held 200 cycles, plus one 4-cycle SW=12 blip -> SW_clean follows each value within 19 cycles and never shows 12.
REQ-038 Scenario 5: assert nReset while Buttons[0]=1, then release reset with KEY[0] still low -> after reset there is no release_pulse, and press_pulse[0] fires 18 cycles after reset deassertion.
REQ-039 Scenario 6: sweep the prescaler through more than 3 wraps with SW constant -> SW_clean is stable, with one tick every 8 cycles.
